audio_sample_pacer: RTL and testbench

Pixel-clock-domain audio pacing stage that sits between the SPI-fed stereo audio FIFO and the HDMI transmitter's audio sample input. It derives an exact average AUDIO_RATE sample strobe and a matching clk_audio from clk_pixel with a fractional accumulator, which removes the integer-divider rate error. On each strobe it pops one 32-bit stereo word from the FIFO and presents it as `audio_sample_word`. On underrun it repeats the previous sample and counts the underrun.

---
 rtl/audio_sample_pacer_if.sv | 25 ++
 rtl/audio_sample_pacer.sv | 127 ++++++++++++
 tb/tb_audio_sample_pacer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_sample_pacer_if.sv
// Bundle of control, FIFO and audio-output signals between the pacer and its surroundings.
// The pacer connects through the slave modport; the driving environment uses master.
interface audio_sample_pacer_if;
  logic              enable;
  logic              mute;
  logic              clear_underrun;
  logic              fifo_empty;
  logic              fifo_rden;
  logic [31:0]       fifo_q;
  logic [1:0][15:0]  audio_sample_word;
  logic              clk_audio;
  logic              sample_strobe;
  logic              underrun;
  logic [15:0]       underrun_count;

  modport master (
    output enable, mute, clear_underrun, fifo_empty, fifo_q,
    input  fifo_rden, audio_sample_word, clk_audio, sample_strobe, underrun, underrun_count
  );

  modport slave (
    input  enable, mute, clear_underrun, fifo_empty, fifo_q,
    output fifo_rden, audio_sample_word, clk_audio, sample_strobe, underrun, underrun_count
  );
endinterface

// File: rtl/audio_sample_pacer.sv
// Paces stereo audio samples out of a FIFO at an exact average AUDIO_RATE derived from
// clk_pixel by a fractional accumulator; repeats the last sample and counts underruns.
module audio_sample_pacer #(
  parameter int unsigned CLK_HZ     = 75_000_000,
  parameter int unsigned AUDIO_RATE = 48_000
) (
  input  logic                  i_clk_pixel,
  input  logic                  i_reset,
  audio_sample_pacer_if.slave   io_bus
);

  // CLK_HZ < 2^31 and AUDIO_RATE <= CLK_HZ/4 keep acc + AUDIO_RATE inside 32 bits.
  localparam logic [31:0] LP_CLK  = 32'(CLK_HZ);
  localparam logic [31:0] LP_RATE = 32'(AUDIO_RATE);
  localparam logic [31:0] LP_HALF = 32'(CLK_HZ / 2);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic [31:0]  r_acc;
  logic [31:0]  w_sum;
  logic [31:0]  w_acc_next;
  logic         w_tick;
  logic         w_rden;
  logic         w_miss;
  logic         r_clk_audio;
  logic [31:0]  r_word;
  logic         r_underrun;
  logic [15:0]  r_underrun_count;

  // Fractional accumulator: tick on the cycle whose add would reach CLK_HZ.
  always_comb begin
    w_sum      = r_acc + LP_RATE;
    w_tick     = 1'b0;
    w_acc_next = 32'd0;
    if (io_bus.enable) begin
      if (w_sum >= LP_CLK) begin
        w_tick     = 1'b1;
        w_acc_next = w_sum - LP_CLK;
      end else begin
        w_acc_next = w_sum;
      end
    end else begin
      w_acc_next = 32'd0;
    end
  end

  // Read sequencer next-state and FIFO read / underrun decode.
  always_comb begin
    w_state_next = r_state;
    w_rden       = 1'b0;
    w_miss       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_tick) begin
          if (!io_bus.fifo_empty) begin
            w_rden       = 1'b1;
            w_state_next = ST_WAIT;
          end else begin
            w_miss       = 1'b1;
          end
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Accumulator, sample clock and sequencer state registers.
  always_ff @(posedge i_clk_pixel) begin
    if (i_reset) begin
      r_acc       <= 32'd0;
      r_clk_audio <= 1'b0;
      r_state     <= ST_IDLE;
    end else begin
      r_acc       <= w_acc_next;
      r_clk_audio <= (w_acc_next >= LP_HALF);
      r_state     <= w_state_next;
    end
  end

  // Sample capture one cycle after the read; a reset in WAIT drops the capture.
  always_ff @(posedge i_clk_pixel) begin
    if (i_reset) begin
      r_word <= 32'd0;
    end else if (r_state == ST_WAIT) begin
      r_word <= io_bus.mute ? 32'd0 : io_bus.fifo_q;
    end else begin
      r_word <= r_word;
    end
  end

  // Underrun pulse and saturating counter; clear wins over a same-cycle increment.
  always_ff @(posedge i_clk_pixel) begin
    if (i_reset) begin
      r_underrun       <= 1'b0;
      r_underrun_count <= 16'd0;
    end else begin
      r_underrun <= w_miss;
      if (io_bus.clear_underrun) begin
        r_underrun_count <= 16'd0;
      end else if (w_miss && (r_underrun_count != 16'hFFFF)) begin
        r_underrun_count <= r_underrun_count + 16'd1;
      end else begin
        r_underrun_count <= r_underrun_count;
      end
    end
  end

  assign io_bus.fifo_rden         = w_rden;
  assign io_bus.sample_strobe     = w_tick;
  assign io_bus.audio_sample_word = r_word;
  assign io_bus.clk_audio         = r_clk_audio;
  assign io_bus.underrun          = r_underrun;
  assign io_bus.underrun_count    = r_underrun_count;

endmodule

// File: tb/tb_audio_sample_pacer.sv
// Directed bench for audio_sample_pacer at CLK_HZ=100, AUDIO_RATE=3 with a small FIFO model.
module tb_audio_sample_pacer;
  localparam int CLK_HZ = 100;
  localparam int RATE   = 3;
  localparam int FIRST  = 33;   // ceil(100/3) - 1

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  audio_sample_pacer_if bus ();

  audio_sample_pacer #(.CLK_HZ(CLK_HZ), .AUDIO_RATE(RATE)) dut (
    .i_clk_pixel (clk),
    .i_reset     (rst),
    .io_bus      (bus)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears on fifo_q one cycle after fifo_rden.
  logic [31:0] mem [8];
  int wr_ptr   = 0;
  int rd_ptr   = 0;
  int rd_count = 0;
  assign bus.fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (bus.fifo_rden && (wr_ptr != rd_ptr)) begin
      bus.fifo_q <= mem[rd_ptr % 8];
      rd_ptr     <= rd_ptr + 1;
      rd_count   <= rd_count + 1;
    end
  end

  typedef struct {
    logic        push;
    logic [31:0] data;
    logic        mute;
    logic        exp_rden;
    logic        exp_under;
    logic [15:0] exp_count;
    logic [31:0] exp_word;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr % 8] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // Advance cycle by cycle (sampled #1 after negedge) until sample_strobe, bounded.
  task automatic wait_strobe(input string nm);
    int n;
    n = 0;
    while (!bus.sample_strobe && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    if (!bus.sample_strobe) begin
      checks++;
      errors++;
      $display("FAIL %s: no sample_strobe within 60 cycles", nm);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_t;
    int n_strobe;
    int n_bad;
    int first_idx;
    int rd0;

    vecs[0] = '{1'b1, 32'h1234_ABCD, 1'b0, 1'b1, 1'b0, 16'd0, 32'h1234_ABCD};
    vecs[1] = '{1'b1, 32'h8000_7FFF, 1'b0, 1'b1, 1'b0, 16'd0, 32'h8000_7FFF};
    vecs[2] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 16'd1, 32'h8000_7FFF};
    vecs[3] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 16'd2, 32'h8000_7FFF};
    vecs[4] = '{1'b1, 32'h5555_AAAA, 1'b1, 1'b1, 1'b0, 16'd2, 32'h0000_0000};
    vecs[5] = '{1'b1, 32'h0001_FFFF, 1'b0, 1'b1, 1'b0, 16'd2, 32'h0001_FFFF};
    vecs[6] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 16'd3, 32'h0001_FFFF};
    vecs[7] = '{1'b1, 32'h7FFF_8000, 1'b0, 1'b1, 1'b0, 16'd3, 32'h7FFF_8000};

    rst = 1'b1;
    bus.enable = 1'b0;
    bus.mute = 1'b0;
    bus.clear_underrun = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_word", bus.audio_sample_word, 32'h0);
    chk("reset_count", 32'(bus.underrun_count), 32'h0);
    chk("reset_strobe", 32'(bus.sample_strobe), 32'h0);
    chk("reset_underrun", 32'(bus.underrun), 32'h0);
    chk("reset_rden", 32'(bus.fifo_rden), 32'h0);
    chk("reset_clk_audio", 32'(bus.clk_audio), 32'h0);

    // Rate: 1000 enabled cycles with an empty FIFO.
    @(negedge clk);
    rst = 1'b0;
    bus.enable = 1'b1;
    #1;
    last_t = -1;
    n_strobe = 0;
    n_bad = 0;
    first_idx = -1;
    for (int k = 0; k < 1000; k++) begin
      if (k == last_t + 1 && last_t >= 0) begin
        chk("clk_audio_fall", 32'(bus.clk_audio), 32'h0);
        chk("underrun_pulse", 32'(bus.underrun), 32'h1);
      end
      if (bus.sample_strobe) begin
        chk("clk_audio_at_tick", 32'(bus.clk_audio), 32'h1);
        if (first_idx < 0) first_idx = k;
        else if ((k - last_t) != 33 && (k - last_t) != 34) n_bad++;
        last_t = k;
        n_strobe++;
      end
      @(negedge clk); #1;
    end
    chk("strobe_total", 32'(n_strobe), 32'd30);
    chk("strobe_spacing_bad", 32'(n_bad), 32'd0);
    chk("first_tick_index", 32'(first_idx), 32'(FIRST));
    chk("rate_underrun_count", 32'(bus.underrun_count), 32'd30);
    chk("rate_no_reads", 32'(rd_count), 32'd0);

    bus.clear_underrun = 1'b1;
    @(negedge clk); #1;
    bus.clear_underrun = 1'b0;
    chk("clear_count", 32'(bus.underrun_count), 32'd0);

    // Table-driven ticks: data path, underrun, mute.
    for (int i = 0; i < 8; i++) begin
      bus.mute = vecs[i].mute;
      if (vecs[i].push) push(vecs[i].data);
      @(negedge clk); #1;
      wait_strobe($sformatf("vec%0d_wait", i));
      chk($sformatf("vec%0d_rden", i), 32'(bus.fifo_rden), 32'(vecs[i].exp_rden));
      @(negedge clk); #1;
      chk($sformatf("vec%0d_underrun", i), 32'(bus.underrun), 32'(vecs[i].exp_under));
      chk($sformatf("vec%0d_count", i), 32'(bus.underrun_count), 32'(vecs[i].exp_count));
      @(negedge clk); #1;
      chk($sformatf("vec%0d_word", i), bus.audio_sample_word, vecs[i].exp_word);
    end
    bus.mute = 1'b0;

    // Clear in the same cycle as an underrun increment.
    wait_strobe("clr_inc_wait");
    bus.clear_underrun = 1'b1;
    @(negedge clk); #1;
    bus.clear_underrun = 1'b0;
    chk("clr_inc_underrun", 32'(bus.underrun), 32'h1);
    chk("clr_inc_count", 32'(bus.underrun_count), 32'h0);

    // Saturation at 16'hFFFF.
    force dut.r_underrun_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_underrun_count;
    #1;
    chk("sat_preset", 32'(bus.underrun_count), 32'h0000_FFFF);
    wait_strobe("sat_wait");
    @(negedge clk); #1;
    chk("sat_underrun", 32'(bus.underrun), 32'h1);
    chk("sat_count", 32'(bus.underrun_count), 32'h0000_FFFF);

    // Mute with three queued words.
    rd0 = rd_count;
    bus.mute = 1'b1;
    push(32'h1111_2222);
    push(32'h3333_4444);
    push(32'h5555_6666);
    @(negedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      wait_strobe($sformatf("mute%0d_wait", i));
      chk($sformatf("mute%0d_rden", i), 32'(bus.fifo_rden), 32'h1);
      @(negedge clk); #1;
    end
    @(negedge clk); #1;
    chk("mute_reads", 32'(rd_count - rd0), 32'd3);
    chk("mute_fifo_empty", 32'(bus.fifo_empty), 32'h1);
    chk("mute_word", bus.audio_sample_word, 32'h0);
    bus.mute = 1'b0;

    // Restore a non-zero word, then reset during WAIT.
    push(32'h0A0B_0C0D);
    wait_strobe("pre_rst_wait");
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("pre_rst_word", bus.audio_sample_word, 32'h0A0B_0C0D);
    push(32'hCAFE_F00D);
    wait_strobe("rst_wait");
    chk("rst_rden", 32'(bus.fifo_rden), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    chk("rst_word", bus.audio_sample_word, 32'h0);
    @(negedge clk); #1;
    chk("rst_word_after", bus.audio_sample_word, 32'h0);

    // Enable drop mid-period, then first read after re-enable.
    repeat (19) @(negedge clk);
    #1;
    chk("en_clk_audio_high", 32'(bus.clk_audio), 32'h1);
    bus.enable = 1'b0;
    @(negedge clk); #1;
    chk("en_clk_audio_low", 32'(bus.clk_audio), 32'h0);
    push(32'h0BAD_BEEF);
    n_bad = 0;
    for (int k = 0; k < 50; k++) begin
      if (bus.sample_strobe || bus.fifo_rden) n_bad++;
      @(negedge clk); #1;
    end
    chk("disabled_activity", 32'(n_bad), 32'd0);
    bus.enable = 1'b1;
    #1;
    first_idx = -1;
    for (int k = 0; k < 60; k++) begin
      if (bus.fifo_rden && first_idx < 0) first_idx = k;
      if (first_idx < 0) begin
        @(negedge clk); #1;
      end
    end
    chk("reenable_first_read", 32'(first_idx), 32'(FIRST));
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("reenable_word", bus.audio_sample_word, 32'h0BAD_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
